alu_ex_stage: RTL and testbench

//   Registered execute-stage ALU directly downstream of ALU control: consumes the
//   4-bit aluCtr code plus two operands, produces result, zero and overflow.

---
 rtl/alu_ex_if.sv | 24 ++
 rtl/alu_ex_stage.sv | 109 ++++++++++
 tb/tb_alu_ex_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_ex_if.sv
// Handshake bundle for the execute-stage ALU: operand request side and result side.
interface alu_ex_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluCtr;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluRes;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport slave (
    input  in_valid, aluCtr, input1, input2, out_ready,
    output in_ready, out_valid, aluRes, zero, overflow, illegal
  );

  modport master (
    output in_valid, aluCtr, input1, input2, out_ready,
    input  in_ready, out_valid, aluRes, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_ex_stage.sv
// Registered execute-stage ALU with a two-entry output buffer (out reg + skid reg)
// so throughput stays at one op per cycle while in_ready is driven from a flop.
module alu_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_ex_if.slave   bus
);

  localparam int M = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ovf;
    logic             ill;
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  res_t             out_q, skid_q, alu;
  logic             out_valid_q, rdy_q;
  logic [WIDTH-1:0] a, b, sum, diff;
  logic             in_x, out_x;

  assign a     = bus.input1;
  assign b     = bus.input2;
  assign sum   = a + b;
  assign diff  = a - b;
  assign in_x  = bus.in_valid & rdy_q;
  assign out_x = out_valid_q & bus.out_ready;

  always_comb begin
    alu = '0;
    unique case (bus.aluCtr)
      4'b0000: alu.res = a & b;
      4'b0001: alu.res = a | b;
      4'b0010: begin
        alu.res = sum;
        alu.ovf = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      4'b0110: begin
        alu.res = diff;
        alu.ovf = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      // true signed compare, not the sign of a-b, so it stays right on overflow
      4'b0111: alu.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1100: alu.res = ~(a | b);
      default: alu.ill = 1'b1;
    endcase
    alu.zero = (alu.res == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_x) begin
            out_q       <= alu;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
          rdy_q <= 1'b1;
        end
        ONE: begin
          if (in_x && out_x) begin
            out_q <= alu;
          end else if (in_x) begin
            skid_q <= alu;
            state  <= TWO;
            rdy_q  <= 1'b0;
          end else if (out_x) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
          if (!(in_x && !out_x)) rdy_q <= 1'b1;
        end
        TWO: begin
          if (out_x) begin
            out_q <= skid_q;
            state <= ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          rdy_q       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.aluRes    = out_q.res;
  assign bus.zero      = out_q.zero;
  assign bus.overflow  = out_q.ovf;
  assign bus.illegal   = out_q.ill;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Randomized bench for alu_ex_stage: a queue-based reference model is checked every
// cycle, with directed cases pinning arithmetic corners, backpressure and reset.
module tb_alu_ex_stage;

  typedef struct {
    logic [31:0] r;
    bit          z;
    bit          o;
    bit          i;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   seen_edge;
  exp_t q[$];

  alu_ex_if #(.WIDTH(32)) bus ();

  alu_ex_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    e.r = 32'd0; e.o = 1'b0; e.i = 1'b0;
    case (c)
      4'd0:  e.r = a & b;
      4'd1:  e.r = a | b;
      4'd2:  begin s = sa + sb; e.r = s[31:0]; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6:  begin s = sa - sb; e.r = s[31:0]; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: e.r = ~(a | b);
      default: e.i = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(posedge clk or posedge reset)
    if (reset) seen_edge <= 1'b0;
    else       seen_edge <= 1'b1;

  // every-cycle compare against the queue model, then apply this cycle's transfers
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready), 64'd0);
    end else begin
      check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("in_ready",  64'(bus.in_ready), 64'(seen_edge && q.size() < 2));
      if (bus.out_valid && q.size() != 0)
        check("result", {29'd0, bus.zero, bus.overflow, bus.illegal, bus.aluRes},
              {29'd0, q[0].z, q[0].o, q[0].i, q[0].r});
      if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.aluCtr, bus.input1, bus.input2));
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.in_valid = 1'b1; bus.aluCtr = c; bus.input1 = a; bus.input2 = b;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin bad++; total++; $display("FAIL send_timeout: in_ready=0 want 1"); end
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] r, input bit z, input bit o, input bit i);
    @(negedge clk);
    check(name, {30'd0, bus.out_valid, z ? bus.zero : bus.zero, bus.overflow, bus.illegal, bus.aluRes},
          {30'd0, 1'b1, z, o, i, r});
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] ops [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd10};

  initial begin
    exp_t e;
    bus.in_valid = 1'b0; bus.aluCtr = 4'd0; bus.input1 = '0; bus.input2 = '0; bus.out_ready = 1'b1;

    // model pins
    e = model(4'd2, 32'h7FFF_FFFF, 32'd1);  check("pin_add_ovf", {31'd0, e.o, e.r}, {31'd0, 1'b1, 32'h8000_0000});
    e = model(4'd6, 32'h8000_0000, 32'd1);  check("pin_sub_ovf", {31'd0, e.o, e.r}, {31'd0, 1'b1, 32'h7FFF_FFFF});
    e = model(4'd7, 32'hFFFF_FFFF, 32'd1);  check("pin_slt",     64'(e.r), 64'd1);
    e = model(4'd7, 32'h7FFF_FFFF, 32'h8000_0000); check("pin_slt_ovf", 64'(e.r), 64'd0);
    e = model(4'd12, 32'h0F0F_0000, 32'h00F0_0000); check("pin_nor", 64'(e.r), 64'hF000_FFFF);

    repeat (3) @(posedge clk);
    #1;
    check("reset_res", {31'd0, bus.zero, bus.overflow, bus.illegal, bus.aluRes}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // arithmetic corners
    send(4'd2, 32'h7FFF_FFFF, 32'd1); bus.in_valid = 1'b0;
    expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(4'd6, 32'd5, 32'd5); bus.in_valid = 1'b0;
    expect_out("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
    send(4'd7, 32'hFFFF_FFFF, 32'd1); bus.in_valid = 1'b0;
    expect_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
    send(4'd10, 32'h1234_5678, 32'h9ABC_DEF0); bus.in_valid = 1'b0;
    expect_out("illegal", 32'd0, 1'b1, 1'b0, 1'b1);

    // back-to-back logic ops at full rate
    send(4'd0, 32'hF0F0_1234, 32'hFF00_FF00);
    send(4'd1, 32'h0000_00F0, 32'h0F00_0000);
    send(4'd12, 32'h0F0F_0F0F, 32'hF0F0_0000);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);

    // backpressure fills both entries
    #1 bus.out_ready = 1'b0;
    send(4'd2, 32'd1, 32'd2);
    send(4'd6, 32'd10, 32'd3);
    bus.aluCtr = 4'd0; bus.input1 = 32'hAAAA_5555; bus.input2 = 32'hFFFF_0000; bus.in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_hold_res", 64'(bus.aluRes), 64'd3);
    @(negedge clk);
    check("full_hold_res2", 64'(bus.aluRes), 64'd3);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    send(4'd0, 32'hAAAA_5555, 32'hFFFF_0000);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);

    // reset while both entries are full
    #1 bus.out_ready = 1'b0;
    send(4'd1, 32'd1, 32'd2);
    send(4'd1, 32'd4, 32'd8);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_reset_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset2", 64'(bus.in_ready), 64'd1);
    check("no_stale", 64'(bus.out_valid), 64'd0);

    // random traffic
    repeat (800) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.aluCtr    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
      bus.input1    = rnd_op();
      bus.input2    = rnd_op();
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
